// File: rtl/trace_capture_unit_pkg.sv
// trace_capture_unit_pkg
// Shared definitions for the trace capture unit: the capture state
// enumeration, the trigger mode encodings, the position of the opcode
// field inside a retired instruction word and the width of one packed
// trace entry.
package trace_capture_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRETRIG  = 2'd1,
        POSTTRIG = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_PC        = 2'd1;
    localparam logic [1:0] TRIG_OPCODE    = 2'd2;
    localparam logic [1:0] TRIG_NEVER     = 2'd3;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    // One entry is packed {pc, instr, wb_en, wb_reg, wb_data}.
    function automatic int entry_width(input int pc_w, input int reg_aw, input int data_w);
        return pc_w + 32 + 1 + reg_aw + data_w;
    endfunction

endpackage

// File: rtl/trace_capture_unit_if.sv
// trace_capture_unit_if
// Bundles the retired-instruction capture record and the readout stream.
//   cap_valid/cap_pc/cap_instr/cap_wb_en/cap_wb_reg/cap_wb_data : capture record
//   rd_valid/rd_ready/rd_data                                  : readout stream
// master: the core / trace consumer side.  slave: the capture unit.
interface trace_capture_unit_if #(
    parameter int PC_W   = 10,
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    import trace_capture_unit_pkg::*;

    localparam int ENTRY_W = entry_width(PC_W, REG_AW, DATA_W);

    logic               cap_valid;
    logic [PC_W-1:0]    cap_pc;
    logic [31:0]        cap_instr;
    logic               cap_wb_en;
    logic [REG_AW-1:0]  cap_wb_reg;
    logic [DATA_W-1:0]  cap_wb_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_reg, cap_wb_data, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_wb_en, cap_wb_reg, cap_wb_data, rd_ready,
        output rd_valid, rd_data
    );

endinterface

// File: rtl/trace_capture_unit_ram.sv
// trace_ram
// DEPTH x WIDTH trace storage with one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
//   clock : write clock
//   we, waddr, wdata : write port
//   raddr, rdata     : combinational read port
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 63
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; storage survives reset on purpose.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_unit.sv
// trace_capture_unit
// Circular trace buffer for retired instructions. After arm, every retired
// record is stored (oldest overwritten once full) until a trigger fires,
// then post_len further records are stored and the buffer is read out
// oldest-first through a valid/ready stream.
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   bus (slave)        : capture record in, readout stream out
//   arm, abort         : start / cancel pulses (abort has priority)
//   trig_mode          : 0 immediate, 1 PC match, 2 opcode match, 3 never
//   trig_value         : trigger compare value
//   post_len           : entries stored after the trigger
//   state, triggered, entry_count : status
// Build option: TRACE_WB_FILTER_EN -- when defined only records with
// cap_wb_en=1 are stored or considered for trigger.
module trace_capture_unit
    import trace_capture_unit_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    trace_capture_unit_if.slave      bus,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [1:0]               trig_mode,
    input  logic [PC_W-1:0]          trig_value,
    input  logic [$clog2(DEPTH)-1:0] post_len,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic [$clog2(DEPTH):0]   entry_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(PC_W, REG_AW, DATA_W);

    state_t             cur_state;
    state_t             next_state;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      post_cnt;
    logic [AW:0]        count;
    logic               trig_flag;
    logic               rec_ok;
    logic               match;
    logic               store;
    logic               trig_hit;
    logic               pop;
    logic               start;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

`ifdef TRACE_WB_FILTER_EN
    assign rec_ok = bus.cap_valid & bus.cap_wb_en;
`else
    assign rec_ok = bus.cap_valid;
`endif

    // Trigger condition for the record presented this cycle.
    always_comb begin
        match = 1'b0;
        case (trig_mode)
            TRIG_IMMEDIATE: match = 1'b1;
            TRIG_PC:        match = (bus.cap_pc == trig_value);
            TRIG_OPCODE:    match = (bus.cap_instr[OPC_HI:OPC_LO] == trig_value[5:0]);
            default:        match = 1'b0;
        endcase
    end

    // Next-state logic and the datapath strobes it implies; abort overrides all.
    always_comb begin
        next_state = cur_state;
        store      = 1'b0;
        trig_hit   = 1'b0;
        pop        = 1'b0;
        start      = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (arm) begin
                        start      = 1'b1;
                        next_state = PRETRIG;
                    end
                end
                PRETRIG: begin
                    if (rec_ok) begin
                        store = 1'b1;
                        if (match) begin
                            trig_hit   = 1'b1;
                            next_state = (post_len == '0) ? DONE : POSTTRIG;
                        end
                    end
                end
                POSTTRIG: begin
                    if (rec_ok) begin
                        store = 1'b1;
                        if (post_cnt == AW'(1)) begin
                            next_state = DONE;
                        end
                    end
                end
                default: begin
                    if (count != '0 && bus.rd_ready) begin
                        pop = 1'b1;
                        if (count == (AW+1)'(1)) begin
                            next_state = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Pointers and counters. rd_ptr always tracks the oldest entry, so it
    // advances with wr_ptr once the buffer is full and old data is overwritten.
    // post_len needs no clipping: its port width already bounds it to DEPTH-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            trig_flag <= 1'b0;
            post_cnt  <= '0;
        end else if (abort) begin
            count     <= '0;
            trig_flag <= 1'b0;
        end else begin
            if (start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                trig_flag <= 1'b0;
            end
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count == (AW+1)'(DEPTH)) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (trig_hit) begin
                trig_flag <= 1'b1;
                post_cnt  <= post_len;
            end else if (store && cur_state == POSTTRIG) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    assign wr_entry = {bus.cap_pc, bus.cap_instr, bus.cap_wb_en, bus.cap_wb_reg, bus.cap_wb_data};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clock (clock),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Readout data is forced to zero whenever nothing valid is offered, so
    // unreset storage never leaks onto the stream.
    assign bus.rd_valid = (cur_state == DONE) && (count != '0);
    assign bus.rd_data  = bus.rd_valid ? rd_entry : '0;
    assign state        = cur_state;
    assign triggered    = trig_flag;
    assign entry_count  = count;

endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit
// Directed scenarios plus a randomized run, all checked every cycle against
// a queue-based reference model of the trace buffer.
module tb_trace_capture_unit;
    import trace_capture_unit_pkg::*;

    localparam int PC_W    = 10;
    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int DEPTH   = 16;
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = entry_width(PC_W, REG_AW, DATA_W);
`ifdef TRACE_WB_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset_n;
    logic            arm;
    logic            abort;
    logic [1:0]      trig_mode;
    logic [PC_W-1:0] trig_value;
    logic [AW-1:0]   post_len;
    logic [1:0]      state;
    logic            triggered;
    logic [AW:0]     entry_count;

    trace_capture_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    trace_capture_unit #(
        .PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .arm         (arm),
        .abort       (abort),
        .trig_mode   (trig_mode),
        .trig_value  (trig_value),
        .post_len    (post_len),
        .state       (state),
        .triggered   (triggered),
        .entry_count (entry_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0..3 as numbered by the state output, the
    // buffer contents oldest-first, the trigger flag and remaining post count.
    int                 m_state = 0;
    logic [ENTRY_W-1:0] m_q[$];
    bit                 m_trig = 1'b0;
    int                 m_post = 0;
    logic [PC_W-1:0]    popped[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit modelMatch(input logic [PC_W-1:0] pc, input logic [31:0] instr);
        case (trig_mode)
            2'd0:    return 1'b1;
            2'd1:    return pc == trig_value;
            2'd2:    return instr[31:26] == trig_value[5:0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelPush(input logic [ENTRY_W-1:0] e);
        m_q.push_back(e);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endtask

    task automatic modelClear();
        m_state = 0;
        m_q.delete();
        m_trig  = 1'b0;
        m_post  = 0;
    endtask

    task automatic checkAll();
        bit                 exp_valid;
        logic [ENTRY_W-1:0] exp_data;
        exp_valid = (m_state == 3) && (m_q.size() > 0);
        exp_data  = exp_valid ? m_q[0] : '0;
        checkOutput("state", 64'(state), 64'(m_state));
        checkOutput("triggered", 64'(triggered), 64'(m_trig));
        checkOutput("entry_count", 64'(entry_count), 64'(m_q.size()));
        checkOutput("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
        checkOutput("rd_data", 64'(bus.rd_data), 64'(exp_data));
    endtask

    // One clock: drive inputs after the falling edge, advance the model by
    // the rules, then compare shortly after the rising edge.
    task automatic applyStimulus(input logic v, input int pc, input logic [31:0] instr,
                                 input logic wb, input logic a, input logic ab, input logic rdy);
        logic [ENTRY_W-1:0] e;
        logic [REG_AW-1:0]  r;
        logic [DATA_W-1:0]  d;
        logic [PC_W-1:0]    p;
        bit                 rec;
        @(negedge clock);
        r = REG_AW'($urandom);
        d = DATA_W'($urandom);
        p = PC_W'(pc);
        bus.cap_valid   = v;
        bus.cap_pc      = p;
        bus.cap_instr   = instr;
        bus.cap_wb_en   = wb;
        bus.cap_wb_reg  = r;
        bus.cap_wb_data = d;
        bus.rd_ready    = rdy;
        arm             = a;
        abort           = ab;
        #1;
        if (bus.rd_valid && rdy && !ab) popped.push_back(bus.rd_data[ENTRY_W-1 -: PC_W]);
        e   = {p, instr, wb, r, d};
        rec = v && (!FILTER || wb);
        if (ab) begin
            modelClear();
        end else begin
            case (m_state)
                0: if (a) modelClear();
                default: ;
            endcase
            case (m_state)
                0: if (a) m_state = 1;
                1: begin
                    if (rec) begin
                        modelPush(e);
                        if (modelMatch(p, instr)) begin
                            m_trig  = 1'b1;
                            m_post  = (int'(post_len) > DEPTH-1) ? DEPTH-1 : int'(post_len);
                            m_state = (m_post == 0) ? 3 : 2;
                        end
                    end
                end
                2: begin
                    if (rec) begin
                        modelPush(e);
                        m_post--;
                        if (m_post == 0) m_state = 3;
                    end
                end
                default: begin
                    if (rdy && m_q.size() > 0) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_state = 0;
                    end
                end
            endcase
        end
        @(posedge clock);
        #1;
        checkAll();
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && state != 2'd0; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic doReset();
        @(negedge clock);
        #2;
        reset_n       = 1'b0;
        arm           = 1'b0;
        abort         = 1'b0;
        bus.cap_valid = 1'b0;
        bus.rd_ready  = 1'b0;
        #1;
        modelClear();
        checkAll();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ins;
        reset_n = 1'b0;
        arm = 1'b0; abort = 1'b0;
        trig_mode = 2'd0; trig_value = '0; post_len = '0;
        bus.cap_valid = 1'b0; bus.cap_pc = '0; bus.cap_instr = '0; bus.cap_wb_en = 1'b0;
        bus.cap_wb_reg = '0; bus.cap_wb_data = '0; bus.rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkAll();
        @(negedge clock);
        reset_n = 1'b1;

        // Immediate trigger, three post entries.
        $display("[TB] immediate trigger");
        trig_mode = 2'd0; post_len = AW'(3); popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, $urandom, 1, 0, 0, 0);
        checkOutput("imm_state", 64'(state), 64'(3));
        checkOutput("imm_count", 64'(entry_count), 64'(4));
        drain();
        checkOutput("imm_npop", 64'(popped.size()), 64'(4));
        for (int k = 0; k < popped.size(); k++) checkOutput("imm_pc", 64'(popped[k]), 64'(k + 1));
        checkOutput("imm_idle", 64'(state), 64'(0));

        // PC match with wrap-around.
        $display("[TB] pc match wrap");
        trig_mode = 2'd1; trig_value = PC_W'(20); post_len = AW'(5); popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 30; i++) applyStimulus(1, i, $urandom, 1, 0, 0, 0);
        checkOutput("pcm_count", 64'(entry_count), 64'(16));
        drain();
        checkOutput("pcm_npop", 64'(popped.size()), 64'(16));
        for (int k = 0; k < popped.size(); k++) checkOutput("pcm_pc", 64'(popped[k]), 64'(10 + k));

        // Opcode match with zero post length.
        $display("[TB] opcode match");
        trig_mode = 2'd2; trig_value = PC_W'(3); post_len = '0; popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) applyStimulus(1, i, {6'h10, 26'($urandom)}, 1, 0, 0, 0);
        checkOutput("opc_pre", 64'(state), 64'(1));
        applyStimulus(1, 7, {6'b000011, 26'($urandom)}, 1, 0, 0, 0);
        checkOutput("opc_done", 64'(state), 64'(3));
        drain();
        checkOutput("opc_npop", 64'(popped.size()), 64'(7));
        if (popped.size() > 0) checkOutput("opc_last", 64'(popped[popped.size()-1]), 64'(7));

        // Backpressure during readout, then abort.
        $display("[TB] backpressure and abort");
        trig_mode = 2'd0; post_len = AW'(7); popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) applyStimulus(1, i, $urandom, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("bp_npop", 64'(popped.size()), 64'(2));
        for (int k = 0; k < popped.size(); k++) checkOutput("bp_pc", 64'(popped[k]), 64'(k + 1));
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("abort_state", 64'(state), 64'(0));
        checkOutput("abort_valid", 64'(bus.rd_valid), 64'(0));

        // Reset in the middle of post-trigger capture.
        $display("[TB] reset mid capture");
        trig_mode = 2'd0; post_len = AW'(10); popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) applyStimulus(1, i, $urandom, 1, 0, 0, 0);
        checkOutput("rst_post", 64'(state), 64'(2));
        doReset();
        checkOutput("rst_count", 64'(entry_count), 64'(0));
        post_len = AW'(1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 50, $urandom, 1, 0, 0, 0);
        applyStimulus(1, 51, $urandom, 1, 0, 0, 0);
        checkOutput("rst_fresh", 64'(entry_count), 64'(2));
        drain();
        checkOutput("rst_npop", 64'(popped.size()), 64'(2));
        for (int k = 0; k < popped.size(); k++) checkOutput("rst_pc", 64'(popped[k]), 64'(50 + k));

        // Alternating write-back enables.
        $display("[TB] write-back enable pattern");
        trig_mode = 2'd0; post_len = AW'(3); popped.delete();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) applyStimulus(1, i, $urandom, logic'(i % 2), 0, 0, 0);
        checkOutput("wb_count", 64'(entry_count), 64'(4));
        drain();
        checkOutput("wb_npop", 64'(popped.size()), 64'(4));
        for (int k = 0; k < popped.size(); k++)
            checkOutput("wb_pc", 64'(popped[k]), FILTER ? 64'(2 * k + 1) : 64'(k + 1));

        // Randomized traffic.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                trig_mode  = 2'($urandom);
                trig_value = PC_W'($urandom_range(0, 7));
                post_len   = AW'($urandom);
            end
            if ($urandom_range(0, 399) == 0) doReset();
            ins = {3'b000, 3'($urandom), 26'($urandom)};
            applyStimulus(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), ins,
                          logic'($urandom), logic'($urandom_range(0, 9) == 0),
                          logic'($urandom_range(0, 79) == 0), logic'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_capture_unit.md
TRACE_CAPTURE_UNIT -- requirements
Module: trace_capture_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter width.
REQ-002 Parameter DATA_W, default 16, write-back data width.
REQ-003 Parameter REG_AW, default 4, register-address width.
REQ-004 Parameter DEPTH, default 16, trace entries; power of two, at least 4.
REQ-005 Port clock  in  1  single clock, rising edge.
REQ-006 Port reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port cap_valid  in  1  one instruction retired this cycle.
REQ-008 Ports cap_pc [PC_W], cap_instr [32], cap_wb_en [1], cap_wb_reg [REG_AW], cap_wb_data [DATA_W]  in  retired-instruction record.
REQ-009 Port arm  in  1  start a capture; pulse.
REQ-010 Port abort  in  1  cancel a capture or readout; pulse.
REQ-011 Port trig_mode  in  2  trigger mode: 0 immediate, 1 PC match, 2 opcode match, 3 never.
REQ-012 Port trig_value  in  PC_W  trigger compare value.
REQ-013 Port post_len  in  clog2(DEPTH)  number of entries captured after the trigger.
REQ-014 Ports rd_valid out 1, rd_ready in 1, rd_data out ENTRY_W  readout stream; ENTRY_W = PC_W+32+1+REG_AW+DATA_W, packed {pc,instr,wb_en,wb_reg,wb_data}.
REQ-015 Ports state out 2, triggered out 1, entry_count out clog2(DEPTH)+1  status.

Function
REQ-016 States: IDLE=0, PRETRIG=1, POSTTRIG=2, DONE=3.
REQ-017 IDLE: arm -> PRETRIG next edge; entry_count, write pointer and triggered clear.
REQ-018 PRETRIG/POSTTRIG: each cap_valid writes one entry at the write pointer; pointer wraps DEPTH-1 -> 0; entry_count saturates at DEPTH, and the oldest entry is overwritten.
REQ-019 Trigger is evaluated only in PRETRIG on a cap_valid cycle; match conditions: mode 0 always, mode 1 cap_pc==trig_value, mode 2 cap_instr[31:26]==trig_value[5:0], mode 3 never.
REQ-020 On trigger: the triggering entry is stored, triggered=1, post counter loads post_len; post_len=0 -> DONE, else -> POSTTRIG.
REQ-021 POSTTRIG: each stored entry decrements the post counter; the store that reaches 0 -> DONE.
REQ-022 post_len is sampled at the trigger; post_len values above DEPTH-1 are clipped to DEPTH-1.
REQ-023 DONE: cap_valid ignored; rd_valid=(entry_count!=0); rd_data is the oldest entry (index = write pointer - entry_count mod DEPTH), combinational from the registered read pointer, zero-latency.
REQ-024 A rd_valid&rd_ready edge pops one entry; the pop that empties the buffer -> IDLE.
REQ-025 abort in any state -> IDLE next edge with entry_count=0 and triggered=0; when arm and abort are asserted together, abort wins.
REQ-026 arm outside IDLE is ignored.

Reset
REQ-027 reset_n low: state=IDLE, pointers=0, entry_count=0, triggered=0, rd_valid=0, rd_data=0; storage array is not reset.
REQ-028 Reset mid-capture or mid-readout discards all entries; no partial readout follows.

Configuration
REQ-029 TRACE_WB_FILTER_EN defined: only cap_valid cycles with cap_wb_en=1 are stored or evaluated for trigger.
REQ-030 TRACE_WB_FILTER_EN undefined: every cap_valid cycle is stored; cap_wb_en is recorded only.

Structure
REQ-031 A shared package holds the state enumeration, the trig_mode encodings, the opcode field position (bits 31:26) and the ENTRY_W function.
REQ-032 One sub-module, trace_ram: DEPTH x ENTRY_W, single write port, asynchronous read port.

Verification
REQ-033 Mode 0, post_len=3, arm, then 4 valids with PC 1,2,3,4 -> DONE, entry_count=4, readout PC 1,2,3,4, then IDLE.
REQ-034 Mode 1, trig_value=20, DEPTH=16, 30 valids with PC 1..30, post_len=5 -> readout PC 10..25 (16 entries, wrap verified).
REQ-035 Mode 2, trig_value=6'b000011 (jal), jal at PC 7, post_len=0 -> DONE on the jal cycle; last read entry PC 7.
REQ-036 rd_ready toggled 1,0,1 during readout -> no entry dropped or duplicated; abort at entry 2 -> IDLE, rd_valid=0.
REQ-037 reset_n low in POSTTRIG -> all outputs zero; a fresh arm captures from entry_count 0.
REQ-038 TRACE_WB_FILTER_EN defined, alternating cap_wb_en over 8 valids, mode 0, post_len=3 -> only the 4 write-back entries are stored.
